// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU,
// owns architectural HI/LO, exports start/busy for D-stage stall logic.
//
// Ports:
//   clk, reset (async, active-low)
//   req, MDUOp[2:0], MDU_A[31:0], MDU_B[31:0]  - E-stage request + operands
//   rd_sel                                     - MDU_out select (0 LO, 1 HI)
//   cancel                                     - abort (MDU_CANCEL_EN only)
//   start, busy, HI[31:0], LO[31:0], MDU_out[31:0]
//
// Optional feature: define MDU_CANCEL_EN to add the cancel port.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  MDUOp,
    input  logic [31:0] MDU_A,
    input  logic [31:0] MDU_B,
    input  logic        rd_sel,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          busy_n;
    logic [31:0]   hi_n, lo_n;
    logic [31:0]   pend_hi, pend_lo, pend_hi_n, pend_lo_n;
    logic          pend_wr, pend_wr_n;
    logic          kill;

    logic          op_mul, op_div, sgn;
    logic [63:0]   a_x, b_x;
    logic [31:0]   a_mag, b_mag, dvs, q_mag, r_mag;
    logic [63:0]   res;
    logic          res_wr;

`ifdef MDU_CANCEL_EN
    assign kill = cancel;
`else
    assign kill = 1'b0;
`endif

    assign op_mul  = (MDUOp == 3'b001) || (MDUOp == 3'b010);
    assign op_div  = (MDUOp == 3'b011) || (MDUOp == 3'b100);
    assign start   = req & (op_mul | op_div) & ~busy;
    assign MDU_out = rd_sel ? HI : LO;

    // One shared multiplier and divider; signedness only changes the
    // operand conditioning and the final sign fix-up.
    always_comb begin
        sgn   = (MDUOp == 3'b001) || (MDUOp == 3'b011);
        a_x   = {{32{sgn & MDU_A[31]}}, MDU_A};
        b_x   = {{32{sgn & MDU_B[31]}}, MDU_B};
        a_mag = (sgn & MDU_A[31]) ? -MDU_A : MDU_A;
        b_mag = (sgn & MDU_B[31]) ? -MDU_B : MDU_B;
        // Divisor forced non-zero so the divider never sees /0;
        // the result is discarded in that case anyway.
        dvs   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / dvs;
        r_mag = a_mag % dvs;
        res    = 64'd0;
        res_wr = 1'b1;
        if (op_mul) begin
            res = a_x * b_x;
        end else if (op_div) begin
            res[31:0]  = (sgn & (MDU_A[31] ^ MDU_B[31])) ? -q_mag : q_mag;
            res[63:32] = (sgn & MDU_A[31]) ? -r_mag : r_mag;
            res_wr     = (MDU_B != 32'd0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            HI      <= 32'd0;
            LO      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            pend_wr <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            busy    <= busy_n;
            HI      <= hi_n;
            LO      <= lo_n;
            pend_hi <= pend_hi_n;
            pend_lo <= pend_lo_n;
            pend_wr <= pend_wr_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        busy_n    = busy;
        hi_n      = HI;
        lo_n      = LO;
        pend_hi_n = pend_hi;
        pend_lo_n = pend_lo;
        pend_wr_n = pend_wr;
        unique case (state)
            IDLE: begin
                if (start && !kill) begin
                    state_n   = RUN;
                    busy_n    = 1'b1;
                    cnt_n     = op_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    pend_hi_n = res[63:32];
                    pend_lo_n = res[31:0];
                    pend_wr_n = res_wr;
                end else if (req && !kill) begin
                    unique case (1'b1)
                        (MDUOp == 3'b101): hi_n = MDU_A;
                        (MDUOp == 3'b110): lo_n = MDU_A;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                if (kill) begin
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    cnt_n     = '0;
                    pend_wr_n = 1'b0;
                end else if (cnt == CW'(1)) begin
                    state_n   = IDLE;
                    busy_n    = 1'b0;
                    cnt_n     = '0;
                    pend_wr_n = 1'b0;
                    if (pend_wr) begin
                        hi_n = pend_hi;
                        lo_n = pend_lo;
                    end
                end else begin
                    cnt_n = cnt - CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: completions (busy falling) are checked
// against queued HI/LO/busy-length expectations.
module tb_e_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  MDUOp;
    logic [31:0] MDU_A, MDU_B;
    logic        rd_sel;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif
    logic        start, busy;
    logic [31:0] HI, LO, MDU_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .MDUOp   (MDUOp),
        .MDU_A   (MDU_A),
        .MDU_B   (MDU_B),
        .rd_sel  (rd_sel),
`ifdef MDU_CANCEL_EN
        .cancel  (cancel),
`endif
        .start   (start),
        .busy    (busy),
        .HI      (HI),
        .LO      (LO),
        .MDU_out (MDU_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] h, input logic [31:0] l,
                        input int c);
        exp_t e;
        e.hi  = h;
        e.lo  = l;
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic exp_start);
        @(posedge clk);
        #1;
        req   = 1'b1;
        MDUOp = op;
        MDU_A = a;
        MDU_B = b;
        #1 chk("start", {31'd0, start}, {31'd0, exp_start});
        @(posedge clk);
        #1;
        req   = 1'b0;
        MDUOp = 3'b000;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_idle: busy still %b after 40 cycles, expected 0", busy);
    endtask

    // Monitor: one scoreboard entry consumed per busy->0 transition.
    initial begin
        bit   pb;
        int   n;
        exp_t e;
        pb = 1'b0;
        n  = 0;
        forever begin
            @(negedge clk);
            if (busy) begin
                n++;
            end else if (pb) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: completion seen, expected none");
                end else begin
                    e = sb.pop_front();
                    chk("done_hi", HI, e.hi);
                    chk("done_lo", LO, e.lo);
                    chk("busy_len", 32'(n), 32'(e.cyc));
                end
                n = 0;
            end
            pb = busy;
        end
    end

    initial begin
        reset  = 1'b1;
        req    = 1'b0;
        MDUOp  = 3'b000;
        MDU_A  = 32'd0;
        MDU_B  = 32'd0;
        rd_sel = 1'b0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        #1 reset = 1'b0;
        #3;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_out", MDU_out, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        issue(OP_MTHI, 32'hAAAA0001, 32'd0, 1'b0);
        issue(OP_MTLO, 32'h00005555, 32'd0, 1'b0);
        rd_sel = 1'b1;
        #1 chk("mthi_out", MDU_out, 32'hAAAA0001);
        rd_sel = 1'b0;
        #1 chk("mtlo_out", MDU_out, 32'h00005555);

        // Reset during the 4th busy cycle of a DIV.
        push(32'd0, 32'd0, 3);
        issue(OP_DIV, 32'd100, 32'd7, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        push(32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
        #1 chk("mult_old_lo", MDU_out, 32'd0);
        wait_idle();

        push(32'h00000002, 32'hFFFFFFFA, 5);
        issue(OP_MULTU, 32'hFFFFFFFE, 32'd3, 1'b1);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
        wait_idle();

        push(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(OP_DIVU, 32'd7, 32'd0, 1'b1);
        wait_idle();

        issue(OP_MTHI, 32'h00001234, 32'd0, 1'b0);
        rd_sel = 1'b1;
        #1 chk("mfhi", MDU_out, 32'h00001234);
        rd_sel = 1'b0;

        // Overflow divide; MULT and MTLO offered while busy are ignored.
        push(32'd0, 32'h80000000, 10);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
        #1 chk("div_old_lo", MDU_out, 32'hFFFFFFFD);
        @(posedge clk);
        #1;
        req   = 1'b1;
        MDUOp = OP_MULT;
        MDU_A = 32'd5;
        MDU_B = 32'd5;
        #1 chk("busy_nostart", {31'd0, start}, 32'd0);
        @(posedge clk);
        #1;
        MDUOp = OP_MTLO;
        MDU_A = 32'h0000DEAD;
        @(posedge clk);
        #1;
        req   = 1'b0;
        MDUOp = 3'b000;
        #1;
        chk("mtlo_ignored", LO, 32'hFFFFFFFD);
        chk("hi_held", HI, 32'h00001234);
        wait_idle();
        #1 chk("div_new_lo", MDU_out, 32'h80000000);

        push(32'h0000000F, 32'h0FFFFFFF, 10);
        issue(OP_DIVU, 32'hFFFFFFFF, 32'd16, 1'b1);
        wait_idle();

        push(32'h3FFFFFFF, 32'h00000001, 5);
        issue(OP_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1);
        wait_idle();

        push(32'h00000001, 32'hFFFFFFFD, 10);
        issue(OP_DIV, 32'd7, 32'hFFFFFFFE, 1'b1);
        wait_idle();

`ifdef MDU_CANCEL_EN
        push(32'h00000001, 32'hFFFFFFFD, 2);
        issue(OP_MULT, 32'd3, 32'd4, 1'b1);
        @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        wait_idle();

        @(posedge clk);
        #1;
        req    = 1'b1;
        MDUOp  = OP_MULT;
        MDU_A  = 32'd9;
        MDU_B  = 32'd9;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        req    = 1'b0;
        MDUOp  = 3'b000;
        cancel = 1'b0;
        #1;
        chk("cancel_start_busy", {31'd0, busy}, 32'd0);
        chk("cancel_hi", HI, 32'h00000001);
        chk("cancel_lo", LO, 32'hFFFFFFFD);
`endif

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
